// File: rtl/arm_cache_ctrl.sv
// arm_cache_ctrl: 2-way set-associative, write-through, no-write-allocate
// data cache between the MEM stage and the SRAM controller.
module arm_cache_ctrl #(
  parameter int ADDR_W = 19,
  parameter int IDX_W  = 6,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              sram_r_en,
  output logic              sram_w_en,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [63:0]       sram_rdata,
  input  logic              sram_ready,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int SETS  = 2 ** IDX_W;
  localparam int TAG_W = ADDR_W - 3 - IDX_W;

  typedef enum logic [1:0] {
    IDLE,
    RD_MISS,
    WR_THRU
  } state_t;

  state_t state;

  logic [1:0][SETS-1:0] valid;
  logic [SETS-1:0]      lru;
  logic [TAG_W-1:0]     tags  [2][SETS];
  logic [31:0]          words [2][SETS][2];

  logic             offset;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;

  assign offset = addr[2];
  assign idx    = addr[2+IDX_W:3];
  assign tag    = addr[ADDR_W-1:3+IDX_W];

  logic [1:0] way_hit;
  logic       hit;
  logic       hit_way;
  logic       victim;
  logic       rd_req;
  logic       wr_req;
  logic       fill;
  logic       wr_upd;
  logic [31:0] hit_word;
  logic [31:0] fill_word;

  always_comb begin
    for (int w = 0; w < 2; w++) begin
      way_hit[w] = valid[w][idx] && (tags[w][idx] == tag);
    end
  end

  assign hit       = |way_hit;
  assign hit_way   = way_hit[1];
  assign victim    = lru[idx];
  assign wr_req    = mem_w_en;
  assign rd_req    = mem_r_en && !mem_w_en;
  assign hit_word  = words[hit_way][idx][offset];
  assign fill_word = offset ? sram_rdata[63:32] : sram_rdata[31:0];

  // Array writes only on the SRAM completion cycle; reset forces IDLE.
  assign fill   = !rst && (state == RD_MISS) && sram_ready;
  assign wr_upd = !rst && (state == WR_THRU) && sram_ready && hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      valid      <= '0;
      lru        <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (wr_req) begin
            state <= WR_THRU;
          end else if (rd_req && hit) begin
            lru[idx] <= ~hit_way;
            if (hit_count != '1) begin
              hit_count <= hit_count + CNT_W'(1);
            end
          end else if (rd_req) begin
            state <= RD_MISS;
            if (miss_count != '1) begin
              miss_count <= miss_count + CNT_W'(1);
            end
          end
        end
        RD_MISS: begin
          if (sram_ready) begin
            valid[victim][idx] <= 1'b1;
            lru[idx]           <= ~victim;
            state              <= IDLE;
          end
        end
        WR_THRU: begin
          if (sram_ready) begin
            if (hit) begin
              lru[idx] <= ~hit_way;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      tags[victim][idx]     <= tag;
      words[victim][idx][0] <= sram_rdata[31:0];
      words[victim][idx][1] <= sram_rdata[63:32];
    end else if (wr_upd) begin
      words[hit_way][idx][offset] <= wdata;
    end
  end

  always_comb begin
    rdata      = '0;
    stall      = 1'b0;
    sram_r_en  = 1'b0;
    sram_w_en  = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          if (wr_req) begin
            stall = 1'b1;
          end else if (rd_req && hit) begin
            rdata = hit_word;
          end else if (rd_req) begin
            stall = 1'b1;
          end
        end
        RD_MISS: begin
          sram_r_en = 1'b1;
          sram_addr = {addr[ADDR_W-1:3], 3'b000};
          stall     = !sram_ready;
          if (sram_ready) begin
            rdata = fill_word;
          end
        end
        WR_THRU: begin
          sram_w_en  = 1'b1;
          sram_addr  = addr;
          sram_wdata = wdata;
          stall      = !sram_ready;
        end
        default: begin
          stall = 1'b0;
        end
      endcase
    end
  end

endmodule
